// File: rtl/mesi_snoop_responder_pkg.sv
// mesi_snoop_responder_pkg: MESI, snoop-op and FSM encodings shared by the snoop responder and its next-state table
package mesi_snoop_responder_pkg;
  typedef enum logic [1:0] {MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11} mesi_e;
  typedef enum logic [1:0] {OP_BUSRD = 2'b00, OP_BUSRDX = 2'b01, OP_BUSUPGR = 2'b10, OP_NOP = 2'b11} snoop_op_e;
  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_RESP, ST_FLUSH, ST_UPDATE} snoop_fsm_e;
  localparam int MESI_W = 2;
  localparam int OP_W   = 2;
endpackage

// File: rtl/mesi_snoop_next_state.sv
// mesi_snoop_next_state: combinational snoop reaction table {op, state, hit} -> {next_state, need_flush, shared, wr_en}
//   op_i, state_i, hit_i : snooped op, MESI state of the looked-up line, tag hit
//   next_state_o         : MESI state after the snoop (unchanged on miss/I/illegal)
//   need_flush_o         : Modified data must go onto the bus first
//   shared_o             : this cache keeps a copy (BusRd hit)
//   wr_en_o              : state actually changes
module mesi_snoop_next_state
  import mesi_snoop_responder_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [MESI_W-1:0] state_i,
  input  logic              hit_i,
  output logic [MESI_W-1:0] next_state_o,
  output logic              need_flush_o,
  output logic              shared_o,
  output logic              wr_en_o
);
  logic act;
  assign act          = hit_i && state_i != MESI_I && op_i != OP_NOP;
  // BusUpgr on M/E cannot happen in a correct system; leave the line untouched
  assign next_state_o = !act ? state_i :
                        op_i == OP_BUSRD  ? MESI_S :
                        op_i == OP_BUSRDX ? MESI_I :
                        state_i == MESI_S ? MESI_I : state_i;
  assign need_flush_o = act && state_i == MESI_M && op_i != OP_BUSUPGR;
  assign shared_o     = act && op_i == OP_BUSRD;
  assign wr_en_o      = act && next_state_o != state_i;
endmodule

// File: rtl/mesi_snoop_responder.sv
// mesi_snoop_responder: snoop-bus responder for one L1; looks up the tag/MESI array, flushes M data, writes back MESI
//   clk, rst_n                    : clock, async active-low reset
//   snoop_valid/op, Address_Com   : incoming bus transaction (ignored while snoop_busy)
//   snoop_busy/done, shared_out   : FSM busy, one-cycle completion, shared response (valid with done)
//   lookup_*                      : tag-array lookup request / response (response valid the cycle after req)
//   flush_req/ack, Data_Bus_Com, data_oe : Modified-line flush handshake and data drive
//   state_wr_*                    : MESI write-back port
//   MESI_PROTO_CHECK_EN           : when defined adds sticky proto_err for illegal snoop/state combinations
module mesi_snoop_responder
  import mesi_snoop_responder_pkg::*;
#(
  parameter int ADDRESSSIZE     = 32,
  parameter int INDEX_SIZE      = 2,
  parameter int BLK_OFFSET_SIZE = 2,
  parameter int TAG_SIZE        = ADDRESSSIZE - INDEX_SIZE - BLK_OFFSET_SIZE,
  parameter int WAY_SIZE        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   snoop_valid,
  input  logic [OP_W-1:0]        snoop_op,
  input  logic [ADDRESSSIZE-1:0] Address_Com,
  output logic                   snoop_busy,
  output logic                   snoop_done,
  output logic                   shared_out,
  output logic                   lookup_req,
  output logic [INDEX_SIZE-1:0]  lookup_index,
  output logic [TAG_SIZE-1:0]    lookup_tag,
  input  logic                   lookup_hit,
  input  logic [WAY_SIZE-1:0]    lookup_way,
  input  logic [MESI_W-1:0]      lookup_state,
  input  logic [ADDRESSSIZE-1:0] blk_rd_data,
  output logic                   flush_req,
  input  logic                   flush_ack,
  output logic [ADDRESSSIZE-1:0] Data_Bus_Com,
  output logic                   data_oe,
  output logic                   state_wr_en,
  output logic [INDEX_SIZE-1:0]  state_wr_index,
  output logic [WAY_SIZE-1:0]    state_wr_way,
  output logic [MESI_W-1:0]      state_wr_val
`ifdef MESI_PROTO_CHECK_EN
  , output logic                 proto_err
`endif
);
  snoop_fsm_e             state_q, state_d;
  logic [OP_W-1:0]        op_q;
  logic [INDEX_SIZE-1:0]  index_q;
  logic [TAG_SIZE-1:0]    tag_q;
  logic [WAY_SIZE-1:0]    way_q;
  logic [ADDRESSSIZE-1:0] data_q;
  logic [MESI_W-1:0]      nxt_q, ns_next;
  logic                   shared_q, wr_q, ns_flush, ns_shared, ns_wr, capture;
  logic                   unused_offset;
  assign unused_offset = ^Address_Com[BLK_OFFSET_SIZE-1:0];
  assign capture       = state_q == ST_IDLE && snoop_valid && snoop_op != OP_NOP;
  mesi_snoop_next_state u_ns (
    .op_i         (op_q),
    .state_i      (lookup_state),
    .hit_i        (lookup_hit),
    .next_state_o (ns_next),
    .need_flush_o (ns_flush),
    .shared_o     (ns_shared),
    .wr_en_o      (ns_wr)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = capture ? ST_LOOKUP : ST_IDLE;
      ST_LOOKUP: state_d = ST_RESP;
      ST_RESP:   state_d = ns_flush ? ST_FLUSH : ST_UPDATE;
      ST_FLUSH:  state_d = flush_ack ? ST_UPDATE : ST_FLUSH;
      default:   state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      index_q  <= '0;
      tag_q    <= '0;
      way_q    <= '0;
      data_q   <= '0;
      nxt_q    <= '0;
      shared_q <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        op_q    <= snoop_op;
        index_q <= Address_Com[INDEX_SIZE+BLK_OFFSET_SIZE-1:BLK_OFFSET_SIZE];
        tag_q   <= Address_Com[ADDRESSSIZE-1 -: TAG_SIZE];
      end
      // lookup response is only valid in RESP; freeze the decision for FLUSH/UPDATE
      if (state_q == ST_RESP) begin
        way_q    <= lookup_way;
        data_q   <= blk_rd_data;
        nxt_q    <= ns_next;
        shared_q <= ns_shared;
        wr_q     <= ns_wr;
      end
    end
  end
`ifdef MESI_PROTO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_err <= 1'b0;
    else if (state_q == ST_RESP && lookup_hit &&
             (lookup_state == MESI_I || (op_q == OP_BUSUPGR && lookup_state[1]))) proto_err <= 1'b1;
  end
`endif
  assign snoop_busy     = state_q != ST_IDLE;
  assign lookup_req     = state_q == ST_LOOKUP;
  assign lookup_index   = index_q;
  assign lookup_tag     = tag_q;
  assign flush_req      = state_q == ST_FLUSH;
  assign data_oe        = state_q == ST_FLUSH;
  assign Data_Bus_Com   = state_q == ST_FLUSH ? data_q : '0;
  assign snoop_done     = state_q == ST_UPDATE;
  assign shared_out     = state_q == ST_UPDATE && shared_q;
  assign state_wr_en    = state_q == ST_UPDATE && wr_q;
  assign state_wr_index = index_q;
  assign state_wr_way   = way_q;
  assign state_wr_val   = nxt_q;
endmodule

// File: tb/tb_mesi_snoop_responder.sv
// tb_mesi_snoop_responder: directed self-checking bench for mesi_snoop_responder
module tb_mesi_snoop_responder;
  logic clk = 1'b0, rst_n = 1'b0, snoop_valid = 1'b0, lookup_hit = 1'b0, flush_ack = 1'b0;
  logic [1:0] snoop_op = 2'b11, lookup_state = 2'b00, lookup_way = 2'b00;
  logic [31:0] Address_Com = '0, blk_rd_data = '0;
  logic snoop_busy, snoop_done, shared_out, lookup_req, flush_req, data_oe, state_wr_en;
  logic [1:0] lookup_index, state_wr_index, state_wr_way, state_wr_val;
  logic [27:0] lookup_tag;
  logic [31:0] Data_Bus_Com;
`ifdef MESI_PROTO_CHECK_EN
  logic proto_err;
`endif
  int n_chk = 0, n_fail = 0;
  mesi_snoop_responder dut (
    .clk(clk), .rst_n(rst_n), .snoop_valid(snoop_valid), .snoop_op(snoop_op), .Address_Com(Address_Com),
    .snoop_busy(snoop_busy), .snoop_done(snoop_done), .shared_out(shared_out),
    .lookup_req(lookup_req), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .lookup_hit(lookup_hit), .lookup_way(lookup_way), .lookup_state(lookup_state), .blk_rd_data(blk_rd_data),
    .flush_req(flush_req), .flush_ack(flush_ack), .Data_Bus_Com(Data_Bus_Com), .data_oe(data_oe),
    .state_wr_en(state_wr_en), .state_wr_index(state_wr_index), .state_wr_way(state_wr_way), .state_wr_val(state_wr_val)
`ifdef MESI_PROTO_CHECK_EN
    , .proto_err(proto_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // presents a request for one capture edge, returns in the LOOKUP cycle
  task automatic start(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                       input logic [1:0] way, input logic [1:0] st, input logic [31:0] data);
    snoop_valid = 1'b1; snoop_op = op; Address_Com = addr;
    lookup_hit = hit; lookup_way = way; lookup_state = st; blk_rd_data = data;
    tick;
    snoop_valid = 1'b0; snoop_op = 2'b11;
  endtask
  task automatic test_reset;
    tick; tick;
    n_chk++; if ({snoop_busy, snoop_done, shared_out, lookup_req, flush_req, data_oe, state_wr_en} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {snoop_busy, snoop_done, shared_out, lookup_req, flush_req, data_oe, state_wr_en}); end
    n_chk++; if ({lookup_index, lookup_tag, Data_Bus_Com, state_wr_index, state_wr_way, state_wr_val} !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {lookup_index, lookup_tag, Data_Bus_Com, state_wr_index, state_wr_way, state_wr_val}); end
`ifdef MESI_PROTO_CHECK_EN
    n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
`endif
    #2 rst_n = 1'b1;
    tick;
  endtask
  task automatic test_busrd_e;
    start(2'b00, 32'h0000_0104, 1'b1, 2'd2, 2'b10, 32'h0);
    n_chk++; if ({lookup_req, snoop_busy, snoop_done} !== 3'b110) begin n_fail++; $display("FAIL rd_e_lookup: got %b expected 110", {lookup_req, snoop_busy, snoop_done}); end
    n_chk++; if ({lookup_index, lookup_tag} !== {2'd1, 28'h10}) begin n_fail++; $display("FAIL rd_e_idx_tag: got %h/%h expected 1/10", lookup_index, lookup_tag); end
    tick;
    n_chk++; if ({lookup_req, snoop_done, state_wr_en} !== 3'b000) begin n_fail++; $display("FAIL rd_e_resp: got %b expected 000", {lookup_req, snoop_done, state_wr_en}); end
    tick;
    n_chk++; if ({snoop_done, shared_out, state_wr_en} !== 3'b111) begin n_fail++; $display("FAIL rd_e_done: got %b expected 111", {snoop_done, shared_out, state_wr_en}); end
    n_chk++; if ({state_wr_index, state_wr_way, state_wr_val} !== 6'b01_10_01) begin n_fail++; $display("FAIL rd_e_write: got %b expected 011001", {state_wr_index, state_wr_way, state_wr_val}); end
    tick;
    n_chk++; if ({snoop_busy, snoop_done, state_wr_en, shared_out} !== 4'b0) begin n_fail++; $display("FAIL rd_e_idle: got %b expected 0000", {snoop_busy, snoop_done, state_wr_en, shared_out}); end
  endtask
  task automatic test_busrdx_flush;
    start(2'b01, 32'h0000_0208, 1'b1, 2'd1, 2'b11, 32'hDEAD_BEEF);
    tick; tick;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if ({flush_req, data_oe, snoop_done, Data_Bus_Com} !== {3'b110, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL flush_hold_%0d: got %b %h expected 110 deadbeef", i, {flush_req, data_oe, snoop_done}, Data_Bus_Com); end
      if (i == 3) flush_ack = 1'b1;
      tick;
    end
    flush_ack = 1'b0;
    n_chk++; if ({flush_req, data_oe, Data_Bus_Com} !== 34'b0) begin n_fail++; $display("FAIL flush_release: got %b %h expected 00 0", {flush_req, data_oe}, Data_Bus_Com); end
    n_chk++; if ({snoop_done, shared_out, state_wr_en} !== 3'b101) begin n_fail++; $display("FAIL flush_done: got %b expected 101", {snoop_done, shared_out, state_wr_en}); end
    n_chk++; if ({state_wr_index, state_wr_way, state_wr_val} !== 6'b10_01_00) begin n_fail++; $display("FAIL flush_write: got %b expected 100100", {state_wr_index, state_wr_way, state_wr_val}); end
    tick;
    n_chk++; if (snoop_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b expected 0", snoop_busy); end
  endtask
  task automatic test_miss;
    flush_ack = 1'b1;
    start(2'b00, 32'h0000_030C, 1'b0, 2'd0, 2'b11, 32'h5555_AAAA);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if ({state_wr_en, flush_req, data_oe} !== 3'b000) begin n_fail++; $display("FAIL miss_nowrite_%0d: got %b expected 000", i, {state_wr_en, flush_req, data_oe}); end
      n_chk++; if (snoop_done !== (i == 2)) begin n_fail++; $display("FAIL miss_done_%0d: got %b expected %b", i, snoop_done, i == 2); end
      if (i == 2) begin n_chk++; if (shared_out !== 1'b0) begin n_fail++; $display("FAIL miss_shared: got %b expected 0", shared_out); end end
      if (i < 2) tick;
    end
    tick;
    flush_ack = 1'b0;
    n_chk++; if ({snoop_busy, state_wr_en} !== 2'b00) begin n_fail++; $display("FAIL miss_idle: got %b expected 00", {snoop_busy, state_wr_en}); end
  endtask
  task automatic test_back_to_back;
    start(2'b00, 32'h0000_000C, 1'b1, 2'd3, 2'b01, 32'h0);
    tick;
    snoop_valid = 1'b1; snoop_op = 2'b01; Address_Com = 32'h0000_01F4;
    tick;
    n_chk++; if ({snoop_done, shared_out, state_wr_en} !== 3'b110) begin n_fail++; $display("FAIL b2b_s_done: got %b expected 110", {snoop_done, shared_out, state_wr_en}); end
    n_chk++; if (lookup_tag !== 28'h0) begin n_fail++; $display("FAIL b2b_ignored: got tag %h expected 0", lookup_tag); end
    lookup_hit = 1'b1; lookup_way = 2'd0; lookup_state = 2'b01;
    tick;
    n_chk++; if ({snoop_busy, snoop_done} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: got %b expected 00", {snoop_busy, snoop_done}); end
    tick;
    snoop_valid = 1'b0; snoop_op = 2'b11;
    n_chk++; if ({lookup_req, lookup_index, lookup_tag} !== {1'b1, 2'd1, 28'h1F}) begin n_fail++; $display("FAIL b2b_capture: got %b %h %h expected 1 1 1f", lookup_req, lookup_index, lookup_tag); end
    tick; tick;
    n_chk++; if ({snoop_done, shared_out, state_wr_en} !== 3'b101) begin n_fail++; $display("FAIL b2b_rdx_done: got %b expected 101", {snoop_done, shared_out, state_wr_en}); end
    n_chk++; if ({state_wr_index, state_wr_way, state_wr_val} !== 6'b01_00_00) begin n_fail++; $display("FAIL b2b_rdx_write: got %b expected 010000", {state_wr_index, state_wr_way, state_wr_val}); end
    tick;
  endtask
  task automatic test_reset_in_flush;
    start(2'b00, 32'h0000_0104, 1'b1, 2'd0, 2'b11, 32'h1234_5678);
    tick; tick;
    n_chk++; if ({flush_req, Data_Bus_Com} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL rst_flush_entry: got %b %h expected 1 12345678", flush_req, Data_Bus_Com); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({flush_req, data_oe, snoop_busy, Data_Bus_Com} !== 35'b0) begin n_fail++; $display("FAIL rst_flush_drop: got %b %h expected 000 0", {flush_req, data_oe, snoop_busy}, Data_Bus_Com); end
    tick;
    n_chk++; if ({state_wr_en, snoop_done} !== 2'b00) begin n_fail++; $display("FAIL rst_flush_nowrite: got %b expected 00", {state_wr_en, snoop_done}); end
    rst_n = 1'b1;
    tick;
    n_chk++; if ({snoop_busy, lookup_req, state_wr_en, lookup_index, lookup_tag} !== '0) begin n_fail++; $display("FAIL rst_flush_idle: got %b %h %h expected 000 0 0", {snoop_busy, lookup_req, state_wr_en}, lookup_index, lookup_tag); end
  endtask
  task automatic test_upgr_illegal;
    start(2'b10, 32'h0000_0108, 1'b1, 2'd0, 2'b11, 32'hFFFF_0000);
    tick;
    n_chk++; if (flush_req !== 1'b0) begin n_fail++; $display("FAIL upgr_m_noflush: got %b expected 0", flush_req); end
    tick;
    n_chk++; if ({snoop_done, state_wr_en, shared_out, flush_req} !== 4'b1000) begin n_fail++; $display("FAIL upgr_m_done: got %b expected 1000", {snoop_done, state_wr_en, shared_out, flush_req}); end
`ifdef MESI_PROTO_CHECK_EN
    n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL upgr_m_proto_err: got %b expected 1", proto_err); end
`endif
    tick;
    start(2'b10, 32'h0000_010C, 1'b1, 2'd3, 2'b01, 32'h0);
    tick; tick;
    n_chk++; if ({snoop_done, state_wr_en, shared_out} !== 3'b110) begin n_fail++; $display("FAIL upgr_s_done: got %b expected 110", {snoop_done, state_wr_en, shared_out}); end
    n_chk++; if ({state_wr_index, state_wr_way, state_wr_val} !== 6'b11_11_00) begin n_fail++; $display("FAIL upgr_s_write: got %b expected 111100", {state_wr_index, state_wr_way, state_wr_val}); end
`ifdef MESI_PROTO_CHECK_EN
    n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL upgr_proto_sticky: got %b expected 1", proto_err); end
`endif
    tick;
  endtask
  initial begin
    test_reset;
    test_busrd_e;
    test_busrdx_flush;
    test_miss;
    test_back_to_back;
    test_reset_in_flush;
    test_upgr_illegal;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
